// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
// Owns the fetch PC, issues word reads over a req/ack handshake, buffers
// returned words with their PCs in a small FIFO and presents the head over
// a valid/ready handshake. Taken-branch redirects flush the FIFO and drop
// any stale in-flight response.
//
// Handshakes:
//   imem: imem_req/imem_addr are held stable from issue through the ack cycle
//         inclusive; imem_ack is a one-cycle pulse with imem_rdata valid in
//         that cycle. An ack while no request is tracked (IDLE) is ignored.
//   core: the head entry transfers on a cycle where inst_valid && inst_ready,
//         unless a redirect occurs in the same cycle (the pop is then void).
//
// Optional feature: define FETCH_ALIGN_CHECK_EN to flag misaligned redirect
// targets on align_fault (sticky until reset) and stop issuing. Without it,
// redirect_pc[1:0] are ignored and align_fault is tied low.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        align_fault
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,  // no request outstanding
        WAIT    = 2'd1,  // request outstanding, data will be kept
        DISCARD = 2'd2   // request outstanding, data will be dropped
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [31:0]   fetch_pc;
    logic [31:0]   fetch_pc_next;
    logic [31:0]   target_pc;
    logic [31:0]   data_mem [DEPTH];
    logic [31:0]   pc_mem   [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          push;
    logic          pop;
    logic          busy_next;
    logic          issue;
    logic          fault_next;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_C) ? '0 : p + PW'(1);
    endfunction

    // Next-state, FIFO bookkeeping and issue decision. A new request is
    // issued in the same cycle the previous one completes (or a redirect
    // lands with nothing outstanding), so imem_req can reassert on the very
    // next cycle and the address always reflects the updated fetch PC.
    always_comb begin
        target_pc     = {redirect_pc[31:2], 2'b00};
        push          = (state == WAIT) && imem_ack && !redirect;
        pop           = inst_valid && inst_ready && !redirect;
        busy_next     = (state != IDLE) && !imem_ack;
        fetch_pc_next = fetch_pc;
        count_next    = count;
        state_next    = state;

`ifdef FETCH_ALIGN_CHECK_EN
        fault_next = align_fault || (redirect && (redirect_pc[1:0] != 2'b00));
`else
        fault_next = 1'b0;
`endif

        if (redirect) begin
            fetch_pc_next = target_pc;
        end else if (push) begin
            fetch_pc_next = fetch_pc + 32'd4;
        end

        if (redirect) begin
            count_next = '0;
        end else begin
            count_next = count + CW'(push) - CW'(pop);
        end

        issue = !busy_next && (count_next < DEPTH_C) && !fault_next;

        if (issue) begin
            state_next = WAIT;
        end else if (busy_next) begin
            if (redirect) begin
                state_next = DISCARD;
            end
        end else begin
            state_next = IDLE;
        end
    end

    // Control registers: state, fetch PC, request outputs, FIFO pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            fetch_pc   <= RESET_PC;
            imem_req   <= 1'b0;
            imem_addr  <= '0;
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            inst_valid <= 1'b0;
        end else begin
            state      <= state_next;
            fetch_pc   <= fetch_pc_next;
            count      <= count_next;
            inst_valid <= (count_next != '0);
            if (issue) begin
                imem_req  <= 1'b1;
                imem_addr <= {fetch_pc_next[31:2], 2'b00};
            end else if (!busy_next) begin
                imem_req  <= 1'b0;
            end
            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= ptr_inc(wr_ptr);
                end
                if (pop) begin
                    rd_ptr <= ptr_inc(rd_ptr);
                end
            end
        end
    end

    // FIFO storage; cleared on reset so the head outputs read zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else if (push) begin
            data_mem[wr_ptr] <= imem_rdata;
            pc_mem[wr_ptr]   <= imem_addr;
        end
    end

    assign inst_out = data_mem[rd_ptr];
    assign inst_pc  = pc_mem[rd_ptr];

`ifdef FETCH_ALIGN_CHECK_EN
    // Sticky misaligned-target flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            align_fault <= 1'b0;
        end else begin
            align_fault <= fault_next;
        end
    end
`else
    logic unused_pc_bits;
    assign unused_pc_bits = ^redirect_pc[1:0];
    assign align_fault    = 1'b0;
`endif

    // The issue rule keeps a slot free for every outstanding request.
    no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && (count == DEPTH_C)));

endmodule
